// File: rtl/i2c_pkg.sv
// Shared state encoding, command width and command field layout for the
// I2C command arbiter and its round-robin picker.
package i2c_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        GAP
    } arb_state_e;

    localparam int CMD_W = 32;

    localparam logic [7:0] OV5640_WR_ADDR = 8'h78;

    // Command word layout: {dev_addr[7:0], reg_addr[15:0], reg_val[7:0]}
    localparam int DEV_LSB = 24;
    localparam int DEV_W   = 8;
    localparam int REG_LSB = 8;
    localparam int REG_W   = 16;
    localparam int VAL_LSB = 0;
    localparam int VAL_W   = 8;

    function automatic logic [DEV_W-1:0] cmd_dev(input logic [CMD_W-1:0] cmd);
        return cmd[DEV_LSB +: DEV_W];
    endfunction

    function automatic logic [REG_W-1:0] cmd_reg(input logic [CMD_W-1:0] cmd);
        return cmd[REG_LSB +: REG_W];
    endfunction

    function automatic logic [VAL_W-1:0] cmd_val(input logic [CMD_W-1:0] cmd);
        return cmd[VAL_LSB +: VAL_W];
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: requester 0 can override via pri0,
// otherwise the first request above ptr wins, wrapping to the lowest set bit.
module rr_pick #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    input  logic             pri0_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [N-1:0] upper;

    always_comb begin
        upper = '0;
        for (int i = 0; i < N; i++) begin
            upper[i] = req_i[i] && (i > int'(ptr_i));
        end
    end

    // Scanning downward lets the lowest set bit be the final assignment.
    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        if (pri0_i && req_i[0]) begin
            idx_o = '0;
        end else if (|upper) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (upper[i]) idx_o = IDX_W'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (req_i[i]) idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Shares one I2C write engine between N command sources: round-robin grant
// with optional requester-0 priority, ack timeout and inter-command gap.
module i2c_cmd_arbiter
    import i2c_pkg::*;
#(
    parameter int N              = 3,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic               clk_100,
    input  logic               rst_100,
    input  logic [N-1:0]       req,
    input  logic [CMD_W*N-1:0] cmd_data,
    input  logic               pri0,
    output logic [N-1:0]       done,
    output logic [N-1:0]       err,
    output logic               busy,
    output logic [CMD_W-1:0]   cfg_send,
    output logic               i2c_req,
    input  logic               i2c_ack,
    output logic [15:0]        cmd_cnt
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0]      GAP_LAST = 16'(GAP_CYCLES - 1);

    arb_state_e       state_q;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] grant_q;
    logic [TMR_W-1:0] tmr_q;
    logic [15:0]      gap_q;
    logic [N-1:0]     done_q;
    logic [N-1:0]     err_q;
    logic             busy_q;
    logic             i2c_req_q;
    logic [CMD_W-1:0] cfg_q;
    logic [15:0]      cnt_q;
    logic [15:0]      cnt_d;

    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic [CMD_W-1:0] pick_cmd;
    logic [N-1:0]     grant_oh;

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .pri0_i  (pri0),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    assign pick_cmd = cmd_data[CMD_W*int'(pick_idx) +: CMD_W];
    assign grant_oh = N'(1) << grant_q;
    assign cnt_d    = cnt_q + 16'd1;

    always_ff @(posedge clk_100 or posedge rst_100) begin
        if (rst_100) begin
            state_q   <= IDLE;
            ptr_q     <= IDX_W'(N - 1);
            grant_q   <= '0;
            tmr_q     <= '0;
            gap_q     <= '0;
            done_q    <= '0;
            err_q     <= '0;
            busy_q    <= 1'b0;
            i2c_req_q <= 1'b0;
            cfg_q     <= '0;
            cnt_q     <= '0;
        end else begin
            done_q    <= '0;
            err_q     <= '0;
            i2c_req_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        grant_q   <= pick_idx;
                        ptr_q     <= pick_idx;
                        cfg_q     <= pick_cmd;
                        i2c_req_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    tmr_q   <= '0;
                    state_q <= WAIT_ACK;
                end
                // An ack on the final timeout cycle still counts as success.
                WAIT_ACK: begin
                    if (i2c_ack) begin
                        done_q  <= grant_oh;
                        cnt_q   <= cnt_d;
                        gap_q   <= '0;
                        state_q <= GAP;
                    end else if (tmr_q == TMR_LAST) begin
                        err_q   <= grant_oh;
                        gap_q   <= '0;
                        state_q <= GAP;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                GAP: begin
                    if (gap_q == GAP_LAST) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign done     = done_q;
    assign err      = err_q;
    assign busy     = busy_q;
    assign cfg_send = cfg_q;
    assign i2c_req  = i2c_req_q;
    assign cmd_cnt  = cnt_q;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Randomized bench for i2c_cmd_arbiter against a transaction-schedule model
// derived from the arbitration, timeout and gap rules.
module tb_i2c_cmd_arbiter;

    localparam int N    = 3;
    localparam int GAP  = 2;
    localparam int T    = 100;
    localparam int NCYC = 4000;

    logic              clk_100 = 1'b0;
    logic              rst_100 = 1'b1;
    logic [N-1:0]      req = '0;
    logic [32*N-1:0]   cmd_data = '0;
    logic              pri0 = 1'b0;
    logic              i2c_ack = 1'b0;
    logic [N-1:0]      done;
    logic [N-1:0]      err;
    logic              busy;
    logic [31:0]       cfg_send;
    logic              i2c_req;
    logic [15:0]       cmd_cnt;

    always #5 clk_100 = ~clk_100;

    i2c_cmd_arbiter #(
        .N              (N),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk_100  (clk_100),
        .rst_100  (rst_100),
        .req      (req),
        .cmd_data (cmd_data),
        .pri0     (pri0),
        .done     (done),
        .err      (err),
        .busy     (busy),
        .cfg_send (cfg_send),
        .i2c_req  (i2c_req),
        .i2c_ack  (i2c_ack),
        .cmd_cnt  (cmd_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: one scheduled transaction at a time, described by its cycles.
    bit          have_txn;
    int          t_s, t_e, t_a, t_g;
    bit          t_ok;
    logic [31:0] t_cmd;
    logic [31:0] exp_cfg;
    logic [15:0] exp_cnt;
    int          ptr_m;
    int          next_sample;
    int          rq_st[N];
    bit          rst_done = 1'b0;
    int          suppress_until = -1;
    int          late_ack = -1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", tag, cyc, act, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input bit p, input int ptr);
        if (p && r[0]) return 0;
        for (int k = 1; k <= N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        have_txn    = 1'b0;
        ptr_m       = N - 1;
        exp_cfg     = '0;
        exp_cnt     = '0;
        next_sample = cyc;
        t_a         = -1;
    endtask

    task automatic check_cycle();
        logic [N-1:0] ed;
        logic [N-1:0] ee;
        bit           eb;
        bit           er;
        if (have_txn && cyc == t_s + 1) exp_cfg = t_cmd;
        if (have_txn && cyc == t_e && t_ok) exp_cnt = exp_cnt + 16'd1;
        ed = (have_txn && cyc == t_e && t_ok)  ? N'(1) << t_g : '0;
        ee = (have_txn && cyc == t_e && !t_ok) ? N'(1) << t_g : '0;
        eb = have_txn && cyc >= t_s + 1 && cyc < t_e + GAP;
        er = have_txn && cyc == t_s + 1;
        check_eq("i2c_req", 32'(i2c_req), 32'(er));
        check_eq("busy", 32'(busy), 32'(eb));
        check_eq("done", 32'(done), 32'(ed));
        check_eq("err", 32'(err), 32'(ee));
        check_eq("cfg_send", cfg_send, exp_cfg);
        check_eq("cmd_cnt", 32'(cmd_cnt), 32'(exp_cnt));
    endtask

    task automatic drive_cycle();
        bit in_win;
        bit fin;
        int w;
        int r;
        fin = have_txn && cyc == t_e;
        if (fin) begin
            rq_st[t_g] = 0;
            req[t_g]   = 1'b0;
        end
        pri0 = ($urandom_range(7) == 0);
        for (int k = 0; k < N; k++) begin
            if (suppress_until < 0) begin
                if (rq_st[k] == 0 && !(fin && k == t_g) && $urandom_range(3) == 0) begin
                    rq_st[k] = 1;
                    req[k]   = 1'b1;
                end else if (rq_st[k] == 2 && $urandom_range(15) == 0) begin
                    req[k] = 1'b0;
                end
            end
            if ($urandom_range(1) == 0) cmd_data[32*k +: 32] = $urandom;
        end
        if (suppress_until >= 0 && cyc == suppress_until) begin
            for (int k = 0; k < N; k++) begin
                rq_st[k] = 1;
                req[k]   = 1'b1;
            end
            pri0 = 1'b0;
            suppress_until = -1;
        end
        if (cyc == next_sample) begin
            w = pick(req, pri0, ptr_m);
            if (w < 0) begin
                next_sample = cyc + 1;
            end else begin
                have_txn = 1'b1;
                t_s      = cyc;
                t_g      = w;
                ptr_m    = w;
                t_cmd    = cmd_data[32*w +: 32];
                rq_st[w] = 2;
                r = $urandom_range(7);
                if (r == 0) begin
                    t_ok = 1'b0;
                    t_a  = -1;
                    t_e  = cyc + 2 + T;
                end else begin
                    t_ok = 1'b1;
                    t_a  = cyc + 1 + ((r == 1) ? T : $urandom_range(1, 40));
                    t_e  = t_a + 1;
                end
                next_sample = t_e + GAP;
            end
        end
        in_win  = have_txn && cyc >= t_s + 2 && cyc <= t_e - 1;
        i2c_ack = (have_txn && cyc == t_a) || (cyc == late_ack) ||
                  (!in_win && $urandom_range(5) == 0);
    endtask

    initial begin
        for (int k = 0; k < N; k++) rq_st[k] = 0;
        repeat (3) @(negedge clk_100);
        rst_100 = 1'b0;
        model_reset();
        while (cyc < NCYC) begin
            check_cycle();
            if (!rst_done && cyc > 1500 && have_txn && cyc == t_s + 2 &&
                (t_a < 0 || t_a > cyc + 1)) begin
                rst_done = 1'b1;
                late_ack = t_a;
                #2 rst_100 = 1'b1;
                #1;
                check_eq("rst_done", 32'(done), 32'd0);
                check_eq("rst_err", 32'(err), 32'd0);
                check_eq("rst_busy", 32'(busy), 32'd0);
                check_eq("rst_i2c_req", 32'(i2c_req), 32'd0);
                check_eq("rst_cfg_send", cfg_send, 32'd0);
                check_eq("rst_cmd_cnt", 32'(cmd_cnt), 32'd0);
                @(negedge clk_100);
                cyc++;
                rst_100 = 1'b0;
                model_reset();
                for (int k = 0; k < N; k++) begin
                    rq_st[k] = 0;
                    req[k]   = 1'b0;
                end
                suppress_until = (late_ack >= 0) ? late_ack + 2 : cyc + 4;
                check_cycle();
            end
            drive_cycle();
            @(negedge clk_100);
            cyc++;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_cmd_arbiter.md
Name: i2c_cmd_arbiter

Overview:
- Shares the single I2C write engine (send_i2c: 32-bit command in, one-cycle request pulse, one-cycle ack pulse) between N command sources.
- Typical sources: the power-up camera register sequencer, runtime strobe/flash control, and test-pattern control.
- Arbitrates round-robin with an optional strict priority for requester 0, issues one command at a time, and enforces an ack timeout.
- Inserts a programmable inter-command gap and returns a per-requester done or error pulse.

Parameters:
- N, 3, number of requesters (2..8).
- GAP_CYCLES, 2, idle cycles after each command completes or errors before the next grant; legal range 1..65535.
- TIMEOUT_CYCLES, 2000000, clk_100 cycles to wait for i2c_ack before declaring an error (20 ms).

Ports:
- clk_100  in  1  system clock, 100 MHz.
- rst_100  in  1  asynchronous, active-high reset.
- req  in  N  per-requester level request; held until that requester's done or err.
- cmd_data  in  32*N  requester k command in bits [32k+31:32k]: {dev_addr[7:0], reg_addr[15:0], reg_val[7:0]}.
- pri0  in  1  when high, requester 0 wins over all others.
- done  out  N  one-cycle pulse: command for requester k was acked.
- err  out  N  one-cycle pulse: command for requester k timed out.
- busy  out  1  high in every state except IDLE.
- cfg_send  out  32  command presented to the engine.
- i2c_req  out  1  one-cycle request pulse to the engine.
- i2c_ack  in  1  one-cycle completion pulse from the engine.
- cmd_cnt  out  16  count of acked commands; wraps at 65535.

Behaviour:
- Reset values: all outputs 0; state IDLE; rr pointer = N-1, so requester 0 is favoured first; timers 0.
- FSM states: IDLE, ISSUE, WAIT_ACK, GAP.
- IDLE:
  - req is sampled only in this state.
  - If any req bit is high: winner = 0 if pri0 && req[0]; otherwise the first set bit searching from (ptr+1) mod N upward with wrap.
  - At the clock edge: latch grant index g, load cfg_send with cmd_data[g], set ptr = g, go to ISSUE.
  - Grant is 1 edge after req is seen.
- ISSUE: i2c_req = 1 for exactly this one cycle; clear the timeout counter; go to WAIT_ACK.
- WAIT_ACK:
  - i2c_ack = 1: done[g] = 1 for one cycle (registered, asserted in the first GAP cycle); cmd_cnt += 1; go to GAP.
  - Counter reaches TIMEOUT_CYCLES-1 with no ack: err[g] = 1 for one cycle; go to GAP.
  - Ack and timeout in the same cycle: ack wins.
  - cfg_send is held stable from ISSUE through the end of WAIT_ACK.
- GAP: count GAP_CYCLES cycles, then return to IDLE.
- Requester rule: drop req on the edge after observing done or err. GAP_CYCLES >= 1 guarantees no duplicate issue.
- Requester drops req mid-transaction: the transaction still completes and done/err is still pulsed to that requester.
- i2c_ack in IDLE, ISSUE or GAP: ignored; no done, no count.
- cmd_data changing after grant: no effect, because it was latched.
- Reset mid-operation: immediate return to reset values. The in-flight engine transaction is abandoned, and its late ack is ignored because the block is in IDLE.
- Fairness: with all N requesting continuously, grants rotate 0,1,..,N-1,0. With pri0 held high and req[0] held high, only requester 0 is granted (starvation is the intended behaviour).
- Throughput: one command per (1 + 1 + engine latency + GAP_CYCLES) cycles minimum.

Decomposition:
- Package i2c_pkg:
  - State enum {IDLE, ISSUE, WAIT_ACK, GAP}.
  - CMD_W = 32.
  - OV5640_WR_ADDR = 8'h78.
  - Field-slice constants for dev/reg/val.
- One sub-module, rr_pick: combinational round-robin selector with a priority override.
  - Inputs: req[N], ptr, pri0.
  - Outputs: valid, idx.
  - Instantiated once; FSM, timers and counters stay in the top.

Test Plan:
- Single request: req[1] = 1, cmd_data[1] = 32'h78300882; engine acks 40 cycles after i2c_req -> i2c_req 1 cycle at t+1, cfg_send = 32'h78300882, done[1] pulse in the first GAP cycle, cmd_cnt = 1, busy low GAP_CYCLES later.
- Round-robin: req = 3'b111 held, ack after 10 cycles each -> grant order 0,1,2,0; each done exactly once per issue; no back-to-back issue within the GAP.
- Priority: pri0 = 1, req = 3'b110 then req[0] raised during requester 1's WAIT_ACK -> requester 1 completes, next grant goes to 0, then 2.
- Timeout: TIMEOUT_CYCLES = 100, no ack -> err[g] pulses at cycle 100 after ISSUE; no done; cmd_cnt unchanged; next grant proceeds after the GAP.
- Spurious and simultaneous acks: ack in IDLE -> ignored. Ack on the exact timeout cycle -> done, no err.
- Reset mid-WAIT_ACK: assert rst_100 asynchronously -> all outputs 0 immediately; a later ack is ignored; after release, requester 0 is granted first.
